alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
Register-file and operand-issue stage directly upstream of the yAlu ALU. It holds NREG general registers with two read ports and one writeback port. Each accepted instruction reads its operands, optionally substitutes a sign-extended immediate for operand B, and presents the registered (a, b, op) triple to the ALU under a valid/ready handshake. The ALU result returns through the writeback port.

Parameters:
WIDTH, 32, data width of registers and ALU operands
NREG, 32, number of registers
AW, 5, register address width (2**AW == NREG)
IMMW, 16, immediate width, sign-extended to WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept an instruction this cycle
rs  input  AW  source register for operand A
rt  input  AW  source register for operand B
op_in  input  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
imm  input  IMMW  immediate value
use_imm  input  1  1: B = sign-extended imm; 0: B = R[rt]
wb_en  input  1  writeback enable
wb_addr  input  AW  writeback register
wb_data  input  WIDTH  writeback data (ALU z)
out_valid  output  1  a/b/op hold a valid instruction
out_ready  input  1  ALU side accepts this cycle
a  output  WIDTH  operand A to ALU
b  output  WIDTH  operand B to ALU
op  output  3  op to ALU
op_err  output  1  sticky; set when an accepted op_in is not in the legal set

Behaviour:
- Reset (rst_n low, asynchronous):
  - All NREG registers clear to 0.
  - a, b, op, out_valid and op_err clear to 0.
  - Reset asserted mid-operation discards the held instruction.
- Register 0:
  - Always reads 0.
  - Writes to address 0 are ignored.
- Writeback:
  - When wb_en is high, R[wb_addr] <= wb_data on the rising edge.
  - Writeback is independent of the handshake; it also happens while the stage is stalled.
- Read bypass:
  - If wb_en is high and wb_addr == rs (or rt) and the address is nonzero, the read returns wb_data in the same cycle (write-first).
  - The bypass applies on both read ports independently.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - On accept, on the next edge:
    - a <= read(rs).
    - b <= use_imm ? sext(imm) : read(rt).
    - op <= op_in.
    - out_valid <= 1.
  - If out_ready is high and there is no accept: out_valid <= 0. a, b and op keep their values.
  - If out_valid is high and out_ready is low: a, b, op and out_valid hold unchanged. in_ready is low, so no accept occurs.
  - Simultaneous drain and accept (out_valid, out_ready and in_valid all high): the new instruction replaces the old one with no bubble. Sustained throughput is 1 per cycle.
- Latency:
  - 1 cycle from accept to out_valid.
  - Operands are sampled at accept. A writeback arriving after accept does not update a held a or b (the stage does no forwarding into the output register).
- Sign extension: sext(imm) replicates imm[IMMW-1] into bits WIDTH-1..IMMW.
- op_err:
  - Set on accept of op_in in {011, 100, 101}.
  - Cleared only by reset.
  - The illegal op is still issued unchanged.
- No internal FSM beyond the single-entry valid flag. There are two states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready without accept.
  - FULL -> FULL on stall, or on drain plus accept.

Test Plan:
- Reset then read: after rst_n pulse, issue rs=3, rt=4, op_in=010, use_imm=0 -> next cycle out_valid=1, a=0, b=0, op=010. During reset, out_valid=0 and op_err=0.
- Writeback then read: write R5=0x0000_00FF, then R6=0xFFFF_FF00. Issue rs=5, rt=6, op_in=000 -> a=0x0000_00FF, b=0xFFFF_FF00, op=000. The ALU (yAlu) gives z=0 and zero flag 1.
- Bypass and R0:
  - Same cycle wb_en=1, wb_addr=7, wb_data=0x1234_5678 and issue rs=7 -> a=0x1234_5678.
  - Write 0xDEAD_BEEF to R0, then issue rs=0 -> a=0.
- Immediate path: use_imm=1, imm=0x8000, rs=1 (R1=5), op_in=110 -> b=0xFFFF_8000, a=5. With imm=0x7FFF -> b=0x0000_7FFF.
- Stall and back-pressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0; a, b and op are stable.
  - A writeback to the held rs during the stall does not change a.
  - Raise out_ready -> next instruction is loaded the same edge, with no bubble.
- Illegal op and async reset: accept op_in=101 -> op_err=1 and op=101 is issued. Then drop rst_n mid-cycle with out_valid=1 -> out_valid, op_err and all registers read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : Register file plus single-entry operand-issue stage feeding the
//            yAlu ALU. Two read ports (rs, rt), one writeback port with
//            write-first bypass, optional sign-extended immediate for
//            operand B, and a registered (a, b, op) output under a
//            valid/ready handshake with full 1-per-cycle throughput.
// Ports    : clk, rst_n (async active-low)
//            in_valid/in_ready, rs, rt, op_in, imm, use_imm  - issue side
//            wb_en, wb_addr, wb_data                         - writeback
//            out_valid/out_ready, a, b, op                   - ALU side
//            op_err                                          - sticky flag
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int IMMW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    rs,
    input  logic [AW-1:0]    rt,
    input  logic [2:0]       op_in,
    input  logic [IMMW-1:0]  imm,
    input  logic             use_imm,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [2:0]       op,
    output logic             op_err
);

    // Output-slot occupancy: EMPTY holds nothing, FULL holds one instruction.
    localparam logic [0:0] c_st_empty = 1'b0;
    localparam logic [0:0] c_st_full  = 1'b1;

    logic [WIDTH-1:0] r_regs [NREG];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_op_err;
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;

    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;
    logic [WIDTH-1:0] w_sext;
    logic             w_accept;
    logic             w_illegal;

    // ------------------------------------------------------------------
    // Register file. Entry 0 is never written, so it stays at its reset
    // value of zero; reads of address 0 are also forced to zero below so
    // the bypass can never leak a write aimed at R0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Write-first read ports: a same-cycle writeback to the read address
    // wins over the stored value.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        if (rs != '0) begin
            w_rd_a = (wb_en && (wb_addr == rs)) ? wb_data : r_regs[rs];
        end
        if (rt != '0) begin
            w_rd_b = (wb_en && (wb_addr == rt)) ? wb_data : r_regs[rt];
        end
    end

    assign w_sext    = {{(WIDTH-IMMW){imm[IMMW-1]}}, imm};
    assign w_illegal = (op_in == 3'b011) || (op_in == 3'b100) || (op_in == 3'b101);

    // ------------------------------------------------------------------
    // Handshake. A draining slot can be refilled on the same edge, which
    // is what gives back-to-back issue without a bubble.
    // ------------------------------------------------------------------
    assign out_valid = (r_state == c_st_full);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty: begin
                if (w_accept) begin
                    w_state_nxt = c_st_full;
                end
            end
            c_st_full: begin
                if (w_accept) begin
                    w_state_nxt = c_st_full;
                end else if (out_ready) begin
                    w_state_nxt = c_st_empty;
                end
            end
            default: w_state_nxt = c_st_empty;
        endcase
    end

    // Operand register: sampled only at accept, so later writebacks do not
    // disturb an instruction that is already waiting on the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_op_err <= 1'b0;
        end else if (w_accept) begin
            r_a  <= w_rd_a;
            r_b  <= use_imm ? w_sext : w_rd_b;
            r_op <= op_in;
            if (w_illegal) begin
                r_op_err <= 1'b1;
            end
        end
    end

    assign a      = r_a;
    assign b      = r_b;
    assign op     = r_op;
    assign op_err = r_op_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Purpose  : Self-checking bench for alu_operand_stage: directed vector table,
//            hand-written stall / illegal-op / async-reset sequences, and a
//            randomized phase checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [2:0]  op_in;
    logic [15:0] imm;
    logic        use_imm;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        op_err;

    int npass  = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(
        .WIDTH (32),
        .NREG  (32),
        .AW    (5),
        .IMMW  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs        (rs),
        .rt        (rt),
        .op_in     (op_in),
        .imm       (imm),
        .use_imm   (use_imm),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .op_err    (op_err)
    );

    typedef struct {
        logic        iv;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [2:0]  op;
        logic [15:0] imm;
        logic        ui;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ordy;
        logic        x_rdy;
        logic        x_valid;
        logic [31:0] x_a;
        logic [31:0] x_b;
        logic [2:0]  x_op;
        logic        x_err;
    } vec_t;

    vec_t vecs [9];
    vec_t v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t t);
        in_valid  = t.iv;
        rs        = t.rs;
        rt        = t.rt;
        op_in     = t.op;
        imm       = t.imm;
        use_imm   = t.ui;
        wb_en     = t.we;
        wb_addr   = t.wa;
        wb_data   = t.wd;
        out_ready = t.ordy;
    endtask

    // One clock: drive at negedge, check in_ready before the edge,
    // check registered outputs just after it.
    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        drive(t);
        #1;
        chk($sformatf("%s.in_ready", tag), 32'(in_ready), 32'(t.x_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("%s.out_valid", tag), 32'(out_valid), 32'(t.x_valid));
        chk($sformatf("%s.a", tag), a, t.x_a);
        chk($sformatf("%s.b", tag), b, t.x_b);
        chk($sformatf("%s.op", tag), 32'(op), 32'(t.x_op));
        chk($sformatf("%s.op_err", tag), 32'(op_err), 32'(t.x_err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural model for the random phase ----------------
    logic [31:0] mreg [32];
    logic        m_valid;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  m_op;
    logic        m_err;

    function automatic logic [31:0] mread(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        if (wb_en && wb_addr == addr) return wb_data;
        return mreg[addr];
    endfunction

    initial begin
        vec_t idle;
        idle = '{1'b0, 5'd0, 5'd0, 3'd0, 16'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1,
                 1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0};
        drive(idle);
        rst_n = 1'b0;
        #12;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.op_err", 32'(op_err), 32'd0);
        chk("reset.a", a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //          iv rs    rt    op    imm        ui  we  wa    wd             ordy rdy vld a              b              op    err
        vecs[0] = '{1, 5'd3, 5'd4, 3'd2, 16'h0000, 0, 0, 5'd0, 32'h0,        1,   1,  1, 32'h0,        32'h0,        3'd2, 0};
        vecs[1] = '{0, 5'd0, 5'd0, 3'd0, 16'h0000, 0, 1, 5'd5, 32'h000000FF, 1,   1,  0, 32'h0,        32'h0,        3'd2, 0};
        vecs[2] = '{0, 5'd0, 5'd0, 3'd0, 16'h0000, 0, 1, 5'd6, 32'hFFFFFF00, 1,   1,  0, 32'h0,        32'h0,        3'd2, 0};
        vecs[3] = '{1, 5'd5, 5'd6, 3'd0, 16'h0000, 0, 0, 5'd0, 32'h0,        1,   1,  1, 32'h000000FF, 32'hFFFFFF00, 3'd0, 0};
        vecs[4] = '{1, 5'd7, 5'd0, 3'd1, 16'h0000, 0, 1, 5'd7, 32'h12345678, 1,   1,  1, 32'h12345678, 32'h0,        3'd1, 0};
        vecs[5] = '{1, 5'd0, 5'd7, 3'd2, 16'h0000, 0, 1, 5'd0, 32'hDEADBEEF, 1,   1,  1, 32'h0,        32'h12345678, 3'd2, 0};
        vecs[6] = '{0, 5'd0, 5'd0, 3'd0, 16'h0000, 0, 1, 5'd1, 32'h00000005, 1,   1,  0, 32'h0,        32'h12345678, 3'd2, 0};
        vecs[7] = '{1, 5'd1, 5'd0, 3'd6, 16'h8000, 1, 0, 5'd0, 32'h0,        1,   1,  1, 32'h00000005, 32'hFFFF8000, 3'd6, 0};
        vecs[8] = '{1, 5'd1, 5'd0, 3'd6, 16'h7FFF, 1, 0, 5'd0, 32'h0,        1,   1,  1, 32'h00000005, 32'h00007FFF, 3'd6, 0};
        for (int i = 0; i < 9; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Stall: held instruction (a=5, b=7FFF, op=110) must not move; a
        // writeback to its rs (R1) during the stall must not reach a.
        for (int i = 0; i < 3; i++) begin
            v = '{1, 5'd5, 5'd6, 3'd7, 16'h0, 0, (i == 1), 5'd1, 32'h00000099, 0,
                  0, 1, 32'h00000005, 32'h00007FFF, 3'd6, 0};
            apply(v, $sformatf("stall%0d", i));
        end
        // Drain plus accept on the same edge: no bubble.
        v = '{1, 5'd5, 5'd6, 3'd7, 16'h0, 0, 0, 5'd0, 32'h0, 1,
              1, 1, 32'h000000FF, 32'hFFFFFF00, 3'd7, 0};
        apply(v, "nobubble");
        // Illegal op is issued unchanged and sets the sticky flag.
        v = '{1, 5'd1, 5'd0, 3'd5, 16'h0, 0, 0, 5'd0, 32'h0, 1,
              1, 1, 32'h00000099, 32'h0, 3'd5, 1};
        apply(v, "illegal");
        // Stall with the slot full, then async reset mid-cycle.
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.out_valid", 32'(out_valid), 32'd0);
        chk("areset.op_err", 32'(op_err), 32'd0);
        chk("areset.a", a, 32'd0);
        chk("areset.b", b, 32'd0);
        chk("areset.op", 32'(op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Register file must have been cleared as well.
        v = '{1, 5'd5, 5'd6, 3'd2, 16'h0, 0, 0, 5'd0, 32'h0, 1,
              1, 1, 32'h0, 32'h0, 3'd2, 0};
        apply(v, "postrst0");
        v = '{1, 5'd1, 5'd7, 3'd2, 16'h0, 0, 0, 5'd0, 32'h0, 1,
              1, 1, 32'h0, 32'h0, 3'd2, 0};
        apply(v, "postrst1");

        // ---------------- randomized phase ----------------
        drive(idle);
        do_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        m_valid = 1'b0;
        m_a = 32'd0;
        m_b = 32'd0;
        m_op = 3'd0;
        m_err = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic rdy;
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            rs        = 5'($urandom_range(0, 7));
            rt        = 5'($urandom_range(0, 7));
            op_in     = 3'($urandom_range(0, 7));
            // Mostly legal ops so op_err is not stuck high from the start.
            if (op_in inside {3'd3, 3'd4, 3'd5} && $urandom_range(0, 15) != 0) op_in = 3'd2;
            imm       = 16'($urandom);
            use_imm   = $urandom_range(0, 1) == 1;
            wb_en     = $urandom_range(0, 1) == 1;
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            rdy = !m_valid || out_ready;
            chk("rand.in_ready", 32'(in_ready), 32'(rdy));
            if (in_valid && rdy) begin
                m_a     = mread(rs);
                m_b     = use_imm ? 32'($signed(imm)) : mread(rt);
                m_op    = op_in;
                m_valid = 1'b1;
                if (op_in == 3'd3 || op_in == 3'd4 || op_in == 3'd5) m_err = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en && wb_addr != 5'd0) mreg[wb_addr] = wb_data;
            @(posedge clk);
            #1;
            chk("rand.out_valid", 32'(out_valid), 32'(m_valid));
            chk("rand.a", a, m_a);
            chk("rand.b", b, m_b);
            chk("rand.op", 32'(op), 32'(m_op));
            chk("rand.op_err", 32'(op_err), 32'(m_err));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
`default_nettype wire
